// File: rtl/sico_rec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sico_rec_arbiter
// Purpose  : Round-robin arbiter that shares one recorder channel between
//            NREQ requesters. The winner's {index, data} and the cycle stamp
//            of its grant are registered into a single output slot that the
//            recorder drains with its own ready.
// Ports    :
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   en_i         in   arbitration enable (draining continues when low)
//   req_valid_i  in   [NREQ]        per-requester valid
//   req_data_i   in   [NREQ*WIDTH]  requester r data at [r*WIDTH +: WIDTH]
//   req_ready_o  out  [NREQ]        one-hot grant (or zero)
//   rec_vld_o    out  output slot holds a value
//   rec_ready_i  in   recorder accepts the slot this cycle
//   rec_val_o    out  [IDXW+WIDTH]  {index, data} of the held value
//   rec_cycle_o  out  [CYCW]        cycle stamp of the held value
//   busy_cnt_o   out  [CYCW]        saturating count of blocked-request cycles
// Revision : 1.0 - initial release
// ============================================================================
module sico_rec_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int CYCW  = 32,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  rec_vld_o,
    input  logic                  rec_ready_i,
    output logic [IDXW+WIDTH-1:0] rec_val_o,
    output logic [CYCW-1:0]       rec_cycle_o,
    output logic [CYCW-1:0]       busy_cnt_o
);

    // Slot state encoding
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    // Pointer reset value makes requester 0 the first winner after reset
    localparam logic [IDXW-1:0] c_ptr_rst = IDXW'(NREQ - 1);
    localparam logic [CYCW-1:0] c_cnt_max = {CYCW{1'b1}};

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [IDXW-1:0]       r_ptr;
    logic [CYCW-1:0]       r_cyc;
    logic [CYCW-1:0]       r_stamp;
    logic [CYCW-1:0]       r_busy;
    logic [IDXW+WIDTH-1:0] r_val;

    logic                  w_found;
    logic [IDXW-1:0]       w_win_idx;
    logic [IDXW-1:0]       w_cand;
    logic [WIDTH-1:0]      w_win_data;
    logic                  w_slot_free;
    logic                  w_grant;
    logic                  w_blocked;

    // Rotating search: first valid requester starting at ptr+1, wrapping.
    always_comb begin
        int v_k;
        v_k       = 0;
        w_cand    = '0;
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            v_k    = (int'(r_ptr) + i) % NREQ;
            w_cand = v_k[IDXW-1:0];
            if (!w_found && req_valid_i[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    assign w_win_data  = req_data_i[int'(w_win_idx)*WIDTH +: WIDTH];

    // A full slot being drained this cycle can be refilled in the same cycle.
    assign w_slot_free = (r_state == c_st_empty) || rec_ready_i;

    // Gating with rst_ni keeps the grant quiet while reset is asserted, since
    // the handshake is combinational and would otherwise be lost silently.
    assign w_grant     = rst_ni && en_i && w_slot_free && w_found;
    assign w_blocked   = (|req_valid_i) && !w_grant;

    assign req_ready_o = w_grant ? (NREQ'(1) << w_win_idx) : '0;

    // Slot next-state
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = c_st_full;
        end else if ((r_state == c_st_full) && rec_ready_i) begin
            w_state_nxt = c_st_empty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_empty;
            r_ptr   <= c_ptr_rst;
            r_cyc   <= '0;
            r_stamp <= '0;
            r_busy  <= '0;
            r_val   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= r_cyc + 1'b1;
            if (w_grant) begin
                r_val   <= {w_win_idx, w_win_data};
                r_stamp <= r_cyc;
                r_ptr   <= w_win_idx;
            end
            if (w_blocked && (r_busy != c_cnt_max)) begin
                r_busy <= r_busy + 1'b1;
            end
        end
    end

    assign rec_vld_o   = (r_state == c_st_full);
    assign rec_val_o   = r_val;
    assign rec_cycle_o = r_stamp;
    assign busy_cnt_o  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sico_rec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sico_rec_arbiter
// Purpose  : Self-checking bench for sico_rec_arbiter. Two instances share the
//            stimulus: a 32-bit stamp instance and a 4-bit stamp instance for
//            wrap and saturation behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sico_rec_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           rec_ready;
    logic [N-1:0]   vld;
    logic [N*W-1:0] data;

    logic [N-1:0]   rdy;
    logic           vld_o;
    logic [W+1:0]   val_o;
    logic [31:0]    cyc_o;
    logic [31:0]    busy_o;

    logic [N-1:0]   rdy_s;
    logic           vld_s;
    logic [W+1:0]   val_s;
    logic [3:0]     cyc_s;
    logic [3:0]     busy_s;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_ptr;
    int          m_cyc;
    int          m_busy;
    int          m_stamp;
    bit          m_full;
    logic [1:0]  m_idx;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    sico_rec_arbiter #(.NREQ(N), .WIDTH(W), .CYCW(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .req_valid_i(vld), .req_data_i(data), .req_ready_o(rdy),
        .rec_vld_o(vld_o), .rec_ready_i(rec_ready), .rec_val_o(val_o),
        .rec_cycle_o(cyc_o), .busy_cnt_o(busy_o)
    );

    sico_rec_arbiter #(.NREQ(N), .WIDTH(W), .CYCW(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .req_valid_i(vld), .req_data_i(data), .req_ready_o(rdy_s),
        .rec_vld_o(vld_s), .rec_ready_i(rec_ready), .rec_val_o(val_s),
        .rec_cycle_o(cyc_s), .busy_cnt_o(busy_s)
    );

    // Winner under the current inputs, or -1 when nothing is granted.
    function automatic int exp_winner();
        if (!en || (m_full && !rec_ready)) return -1;
        for (int i = 1; i <= N; i++) begin
            int k = (m_ptr + i) % N;
            if (vld[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w = exp_winner();
        if (w < 0) return '0;
        return 4'(1 << w);
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_cyc = 0; m_busy = 0; m_stamp = 0;
        m_full = 0; m_idx = '0; m_data = '0;
    endtask

    // Advance the model over the coming rising edge, then wait to the next
    // falling edge where inputs are changed and outputs sampled.
    task automatic tick();
        int w;
        w = exp_winner();
        if (w >= 0) begin
            m_full = 1; m_idx = w[1:0]; m_data = data[w*W +: W];
            m_stamp = m_cyc; m_ptr = w;
        end else if (m_full && rec_ready) begin
            m_full = 0;
        end
        if (w < 0 && vld != '0) m_busy++;
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit e, input logic [N-1:0] v, input bit rr);
        en = e; vld = v; rec_ready = rr;
        #1;
    endtask

    task automatic randomize_data();
        for (int r = 0; r < N; r++) data[r*W +: W] = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; randomize_data();
        en = 1'b1; vld = '1; rec_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (rdy !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy); end
        checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", vld_o); end
        checks++; if (val_o !== '0) begin failures++; $display("FAIL reset_val got=%h exp=0", val_o); end
        checks++; if (cyc_o !== '0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", cyc_o); end
        checks++; if (busy_o !== '0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy_o); end
        @(negedge clk);
        rst_n = 1'b1; model_reset();
        drive(1, 4'hF, 1);
        checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL reset_first_winner got=%b exp=0001", rdy); end
        drive(1, 4'h0, 1);
        tick();
    endtask

    task automatic test_rotation();
        for (int k = 0; k < N; k++) data[k*W +: W] = 32'hA0 + k;
        for (int k = 0; k < N; k++) begin
            drive(1, 4'hF, 1);
            checks++;
            if (rdy !== 4'(1 << k)) begin failures++; $display("FAIL rot_grant k=%0d got=%b exp=%b", k, rdy, 4'(1 << k)); end
            if (k > 0) begin
                checks++;
                if (val_o !== {2'(k-1), 32'(32'hA0 + k - 1)} || cyc_o !== 32'(k)) begin
                    failures++; $display("FAIL rot_out k=%0d got=%h/%0d exp=%h/%0d", k, val_o, cyc_o, {2'(k-1), 32'(32'hA0 + k - 1)}, k);
                end
            end
            tick();
        end
        drive(1, 4'h0, 1);
        checks++;
        if (vld_o !== 1'b1 || val_o !== {2'd3, 32'hA3} || cyc_o !== 32'd4) begin
            failures++; $display("FAIL rot_last got=%b/%h/%0d exp=1/%h/4", vld_o, val_o, cyc_o, {2'd3, 32'hA3});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] d2, b0;
        randomize_data();
        drive(1, 4'b0100, 1);
        checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL bp_first got=%b exp=0100", rdy); end
        d2 = data[2*W +: W];
        tick();
        b0 = busy_o;
        for (int c = 0; c < 3; c++) begin
            drive(1, 4'b0100, 0);
            checks++;
            if (vld_o !== 1'b1 || val_o !== {2'd2, d2} || rdy !== '0) begin
                failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%b exp=1/%h/0000", c, vld_o, val_o, rdy, {2'd2, d2});
            end
            tick();
        end
        checks++; if (busy_o !== b0 + 32'd3) begin failures++; $display("FAIL bp_busy got=%0d exp=%0d", busy_o, b0 + 32'd3); end
        data[2*W +: W] = ~d2;
        drive(1, 4'b0100, 1);
        checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL bp_regrant got=%b exp=0100", rdy); end
        tick();
        checks++;
        if (vld_o !== 1'b1 || val_o !== {2'd2, ~d2} || cyc_o !== 32'(m_stamp)) begin
            failures++; $display("FAIL bp_refill got=%b/%h/%0d exp=1/%h/%0d", vld_o, val_o, cyc_o, {2'd2, ~d2}, m_stamp);
        end
    endtask

    task automatic test_ptr_skip();
        randomize_data();
        drive(1, 4'b0010, 1);
        checks++; if (rdy !== 4'b0010) begin failures++; $display("FAIL skip_set got=%b exp=0010", rdy); end
        tick();
        drive(1, 4'b1010, 1);
        checks++; if (rdy !== 4'b1000) begin failures++; $display("FAIL skip_to3 got=%b exp=1000", rdy); end
        tick();
        drive(1, 4'b1010, 1);
        checks++; if (rdy !== 4'b0010) begin failures++; $display("FAIL skip_to1 got=%b exp=0010", rdy); end
        tick();
        checks++;
        if (val_o !== {2'd1, data[1*W +: W]}) begin failures++; $display("FAIL skip_val got=%h exp=%h", val_o, {2'd1, data[1*W +: W]}); end
    endtask

    task automatic test_enable_drain();
        logic [31:0] d0, b0;
        randomize_data();
        d0 = data[W-1:0];
        drive(1, 4'b0001, 1);
        tick();
        b0 = busy_o;
        drive(0, 4'b0001, 1);
        checks++; if (rdy !== '0) begin failures++; $display("FAIL en_noready got=%b exp=0000", rdy); end
        tick();
        checks++;
        if (vld_o !== 1'b0 || busy_o !== b0 + 32'd1 || val_o !== {2'd0, d0}) begin
            failures++; $display("FAIL en_drain got=%b/%0d/%h exp=0/%0d/%h", vld_o, busy_o, val_o, b0 + 32'd1, {2'd0, d0});
        end
        drive(0, 4'b0001, 1);
        tick();
        checks++;
        if (vld_o !== 1'b0 || busy_o !== b0 + 32'd2) begin
            failures++; $display("FAIL en_blocked got=%b/%0d exp=0/%0d", vld_o, busy_o, b0 + 32'd2);
        end
    endtask

    task automatic test_reset_mid();
        randomize_data();
        drive(1, 4'b0100, 1);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (vld_o !== 1'b0 || val_o !== '0 || cyc_o !== '0 || busy_o !== '0 || rdy !== '0) begin
            failures++; $display("FAIL midrst_clear got=%b/%h/%0d/%0d/%b exp=all zero", vld_o, val_o, cyc_o, busy_o, rdy);
        end
        @(negedge clk);
        rst_n = 1'b1; model_reset();
        drive(1, 4'hF, 1);
        checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL midrst_first got=%b exp=0001", rdy); end
        tick();
        checks++;
        if (val_o !== {2'd0, data[W-1:0]} || cyc_o !== '0) begin
            failures++; $display("FAIL midrst_out got=%h/%0d exp=%h/0", val_o, cyc_o, {2'd0, data[W-1:0]});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            randomize_data();
            drive(($urandom % 8) != 0, 4'($urandom), ($urandom % 4) != 0);
            checks++;
            if (rdy !== exp_ready()) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, rdy, exp_ready()); end
            tick();
            checks++;
            if (vld_o !== m_full || val_o !== {m_idx, m_data} || cyc_o !== 32'(m_stamp) || busy_o !== 32'(m_busy)) begin
                failures++;
                $display("FAIL rnd_out c=%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d", c, vld_o, val_o, cyc_o, busy_o, m_full, {m_idx, m_data}, m_stamp, m_busy);
            end
        end
    endtask

    task automatic test_wrap_sat();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; model_reset();
        for (int c = 0; c < 20; c++) begin
            randomize_data();
            drive(1, 4'($urandom_range(1, 15)), 1);
            tick();
            checks++;
            if (vld_s !== m_full || val_s !== {m_idx, m_data} || cyc_s !== 4'(m_stamp % 16)) begin
                failures++; $display("FAIL wrap_out c=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, vld_s, val_s, cyc_s, m_full, {m_idx, m_data}, m_stamp % 16);
            end
        end
        checks++;
        if (cyc_s !== 4'd3 || cyc_o !== 32'd19) begin failures++; $display("FAIL wrap_final got=%0d/%0d exp=3/19", cyc_s, cyc_o); end
        for (int c = 0; c < 20; c++) begin
            drive(0, 4'hF, 1);
            tick();
            checks++;
            if (busy_s !== 4'((m_busy > 15) ? 15 : m_busy)) begin
                failures++; $display("FAIL sat_busy c=%0d got=%0d exp=%0d", c, busy_s, (m_busy > 15) ? 15 : m_busy);
            end
        end
        checks++;
        if (busy_s !== 4'd15 || busy_o !== 32'd20) begin failures++; $display("FAIL sat_final got=%0d/%0d exp=15/20", busy_s, busy_o); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; vld = '0; rec_ready = 1'b0; data = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_backpressure();
        test_ptr_skip();
        test_enable_drain();
        test_reset_mid();
        test_random();
        test_wrap_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sico_rec_arbiter.md
# sico_rec_arbiter

Round-robin arbiter that shares one clocked recorder channel between `NREQ` requesters. Each requester offers a value with a valid/ready handshake; the block grants at most one per cycle and registers the winner's data, index and capture cycle into a single output slot that the recorder stage drains with its own ready. It sits between several monitored sources and one recorder instance, so one channel records an interleaved, source-tagged trace.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 32: data width per requester, 1..1024.
- `CYCW`, default 32: width of the cycle stamp.
- Derived: `IDXW` = max(1, $clog2(NREQ)).

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `en_i`  in  1  arbitration enable; low blocks new grants.
- `req_valid_i`  in  NREQ  per-requester valid.
- `req_data_i`  in  NREQ*WIDTH  requester r's data at bits [r*WIDTH +: WIDTH].
- `req_ready_o`  out  NREQ  per-requester grant/ready; one-hot or zero.
- `rec_vld_o`  out  1  output slot holds a value.
- `rec_ready_i`  in  1  recorder accepts the slot this cycle.
- `rec_val_o`  out  IDXW+WIDTH  {index, data} of the held value.
- `rec_cycle_o`  out  CYCW  cycle stamp of the held value.
- `busy_cnt_o`  out  CYCW  count of cycles with any valid request and no grant.

## Operation
- Free-running cycle counter `cyc`: 0 after reset, +1 every cycle, wraps modulo 2^CYCW.
- Slot states:
  - EMPTY: `rec_vld_o`=0.
  - FULL: `rec_vld_o`=1.
- Slot is free this cycle when EMPTY, or when FULL and `rec_ready_i`=1 (drain and refill in the same cycle).
- Grant condition: `en_i`=1, slot free, and at least one `req_valid_i` bit set.
- Winner is the first valid requester searching upward from `ptr+1`, wrapping modulo NREQ. `ptr` is the last granted index.
- `req_ready_o[w]`=1 for the winner only. It is combinational from `req_valid_i`, `en_i`, slot state, `rec_ready_i` and `ptr`.
- `req_ready_o` is never asserted for a requester whose valid is low.
- On a grant:
  - slot ← {w, data_w}, stamp ← `cyc`, `ptr` ← w, state FULL.
- FULL with `rec_ready_i`=1 and no grant: state EMPTY; `rec_val_o`/`rec_cycle_o` hold their last value.
- FULL with `rec_ready_i`=0: slot, stamp and state unchanged; no grant.
- `busy_cnt_o` increments, saturating at 2^CYCW-1, in every cycle where any `req_valid_i` is set and no grant occurs (blocked by `en_i` or by a full slot).
- `en_i`=0 does not stop draining: a FULL slot still empties on `rec_ready_i`.
- Requesters may drop valid without a grant; no state is kept per requester.
- NREQ=1 degenerates to a registered valid/ready stage with index field 0.

## Timing
- Reset values (async on `rst_ni` low):
  - `rec_vld_o`=0, `rec_val_o`=0, `rec_cycle_o`=0, `busy_cnt_o`=0, `cyc`=0.
  - `ptr`=NREQ-1, so requester 0 wins first after reset.
  - `req_ready_o`=0 while `rst_ni` is low.
- Latency: a value granted in cycle t appears on `rec_vld_o`/`rec_val_o` in cycle t+1, with `rec_cycle_o`=`cyc` of cycle t.
- Throughput: one value per cycle when `rec_ready_i` is held high.
- Fairness: with all NREQ requesters continuously valid and the slot always free, grants rotate 0,1,…,NREQ-1,0,…; each requester waits at most NREQ-1 grants.
- Reset mid-operation: a held slot is discarded, and any handshake in the reset cycle is lost.
- Deassertion of `rst_ni` is synchronised externally; the block needs no internal synchroniser.

## Test plan
- Reset, then NREQ=4, WIDTH=32, all four valid with data 0xA0..0xA3, `rec_ready_i`=1 → grants in cycles 1..4 to 0,1,2,3; output cycles 2..5 carry `rec_val_o`={0,0xA0}…{3,0xA3} with stamps 1..4.
- Requester 2 valid only, `rec_ready_i`=0 for 3 cycles after the first grant → `rec_vld_o` stays 1 with an unchanged value; `req_ready_o`=0; `busy_cnt_o` rises by 3. Then `rec_ready_i`=1 → drain and regrant in the same cycle.
- Requesters 1 and 3 valid, `ptr`=1 → requester 3 wins. Next cycle both still valid → requester 1 wins.
- `en_i`=0 with the slot FULL and `rec_ready_i`=1 → slot drains to EMPTY and no grant; `busy_cnt_o` counts each cycle a request is pending.
- `rst_ni` pulsed low mid-stream with the slot FULL → outputs zero immediately; after release, requester 0 is granted first.
- CYCW=4: run 20 cycles → stamps wrap 15→0. Force 16+ blocked cycles → `busy_cnt_o` saturates at 15.
